sprite_fetch_arbiter: RTL and testbench
=======================================

SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 5, number of requesters (0..3 player blobs, 4 grid-tile renderer).
REQ-002 SHALL have parameter ADDR_W, default 14, sprite ROM address width.
REQ-003 SHALL have parameter DATA_W, default 12, sprite pixel width (4:4:4 RGB).
REQ-004 SHALL have parameter ROM_LAT, default 2, fixed ROM read latency in cycles.
REQ-005 SHALL have port clock  input  1  single clock for all state.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port req_valid  input  N_REQ  per-requester fetch request.
REQ-008 SHALL have port req_addr  input  N_REQ x ADDR_W  per-requester address, held stable while req_valid high.
REQ-009 SHALL have port req_ready  output  N_REQ  one-hot grant, combinational from req_valid and pointer.
REQ-010 SHALL have port flush  input  1  synchronous discard of in-flight reads (pulsed at vsync).
REQ-011 SHALL have port rom_addr  output  ADDR_W  registered ROM address.
REQ-012 SHALL have port rom_en  output  1  registered ROM read strobe.
REQ-013 SHALL have port rom_data  input  DATA_W  ROM data, valid ROM_LAT cycles after rom_en.
REQ-014 SHALL have port resp_valid  output  1  response strobe.
REQ-015 SHALL have port resp_id  output  3  requester index of response.
REQ-016 SHALL have port resp_data  output  DATA_W  returned pixel.
REQ-017 SHALL have port busy  output  1  high while any read is in flight.

Function
REQ-018 SHALL grant at most one requester per cycle; transfer occurs when req_valid[i] and req_ready[i] both high.
REQ-019 SHALL select the grant by round-robin: search indices rr_ptr, rr_ptr+1, ... mod N_REQ, first asserted req_valid wins.
REQ-020 SHALL set rr_ptr to (granted index + 1) mod N_REQ on each transfer; rr_ptr unchanged when no transfer.
REQ-021 SHALL drive req_ready all-zero when no req_valid is high; req_ready never depends on rom_data or flush.
REQ-022 SHALL register rom_addr = req_addr[granted] and rom_en = 1 the cycle after a transfer; rom_en = 0 otherwise, rom_addr holds last value.
REQ-023 SHALL track each issued read in a ROM_LAT+1 deep valid/id shift pipeline; resp_valid, resp_id, resp_data registered, asserting exactly ROM_LAT+1 cycles after rom_en (ROM_LAT+2 after transfer).
REQ-024 SHALL sustain one transfer per cycle with no bubbles when requests are continuous.
REQ-025 SHALL return responses strictly in issue order; resp_data = 0 when resp_valid low.
REQ-026 SHALL, on flush, clear every pipeline valid bit in the same cycle; no resp_valid for reads issued before or in the flush cycle; rr_ptr unaffected; a transfer in the flush cycle is granted but its response is discarded.
REQ-027 SHALL drive busy = OR of rom_en and all pipeline valid bits.
REQ-028 SHALL wrap rr_ptr from N_REQ-1 to 0; out-of-range rr_ptr never occurs.

Reset
REQ-029 SHALL, while reset_n low, force rr_ptr=0, rom_en=0, rom_addr=0, pipeline valid=0, resp_valid=0, resp_id=0, resp_data=0, busy=0; req_ready all-zero.
REQ-030 SHALL discard all in-flight reads on reset assertion mid-operation; first grant after release favours index 0.

Structure
REQ-031 SHALL place N_REQ, requester index constants (REQ_P1..REQ_P4, REQ_GRID) and ROM_LAT default in shared package graphics_pkg.
REQ-032 SHALL implement round-robin pick as sub-module rr_pick (req vector, pointer -> one-hot grant, index); everything else inline.

Verification
REQ-033 SHALL cover: req_valid=5'b00001, addr 0x0123 -> rom_en one cycle later with rom_addr 0x0123, resp_valid/resp_id=0 four cycles after transfer.
REQ-034 SHALL cover: all five held valid from reset -> grant order 0,1,2,3,4,0 on consecutive cycles, six back-to-back responses same order.
REQ-035 SHALL cover: rr_ptr=3, req_valid=5'b00101 -> grant index 0 before 2 (wrap search 3,4,0).
REQ-036 SHALL cover: three reads in flight, flush pulse -> no resp_valid for them, busy low two cycles later, next request returns normally.
REQ-037 SHALL cover: reset_n low with two reads in flight -> all outputs zero, no response after release, first grant to index 0 with all valid.

Source files
------------

// File: rtl/graphics_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | graphics_pkg : shared sprite-fetch constants and helpers             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package graphics_pkg;

  localparam int N_REQ     = 5;
  localparam int REQ_P1    = 0;
  localparam int REQ_P2    = 1;
  localparam int REQ_P3    = 2;
  localparam int REQ_P4    = 3;
  localparam int REQ_GRID  = 4;
  localparam int ROM_LAT   = 2;
  localparam int RESP_ID_W = 3;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : round-robin search from ptr upward, one-hot grant + index  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick
  import graphics_pkg::*;
#(
  parameter int N     = N_REQ,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int w_j;

  // Walk the search order backwards so the earliest candidate overwrites last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    w_j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (req[PTR_W'(w_j)]) begin
        grant                = '0;
        grant[PTR_W'(w_j)]   = 1'b1;
        idx                  = PTR_W'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_fetch_arbiter : round-robin sprite ROM fetch with in-order    |
// | fixed-latency responses and vsync flush.              Rev 1.0        |
// +----------------------------------------------------------------------+
module sprite_fetch_arbiter
  import graphics_pkg::RESP_ID_W, graphics_pkg::ptr_width;
#(
  parameter int N_REQ   = graphics_pkg::N_REQ,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = graphics_pkg::ROM_LAT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         flush,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic                         rom_en,
  input  logic [DATA_W-1:0]            rom_data,
  output logic                         resp_valid,
  output logic [RESP_ID_W-1:0]         resp_id,
  output logic [DATA_W-1:0]            resp_data,
  output logic                         busy
);

  localparam int PTR_W = ptr_width(N_REQ);

  logic [PTR_W-1:0]                r_rr_ptr;
  logic [N_REQ-1:0]                w_grant;
  logic [PTR_W-1:0]                w_idx;
  logic                            w_any;
  logic                            w_xfer;
  logic                            w_resp_fire;
  logic [ADDR_W-1:0]               r_rom_addr;
  logic                            r_rom_en;
  logic [ROM_LAT:0]                r_pipe_v;
  logic [ROM_LAT:0][RESP_ID_W-1:0] r_pipe_id;
  logic                            r_resp_valid;
  logic [RESP_ID_W-1:0]            r_resp_id;
  logic [DATA_W-1:0]               r_resp_data;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Whenever anything is valid it is granted, so a grant is always a transfer.
  assign req_ready   = reset_n ? w_grant : '0;
  assign w_xfer      = reset_n & w_any;
  assign w_resp_fire = r_pipe_v[ROM_LAT] & ~flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_rom_en <= w_xfer;
      if (w_xfer) begin
        r_rom_addr <= req_addr[w_idx];
        r_rr_ptr   <= (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  // Stage k holds a read issued k+1 cycles ago; flush kills every stage at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_v  <= '0;
      r_pipe_id <= '0;
    end else begin
      r_pipe_v[0]  <= w_xfer & ~flush;
      r_pipe_id[0] <= RESP_ID_W'(w_idx);
      for (int k = 1; k <= ROM_LAT; k++) begin
        r_pipe_v[k]  <= r_pipe_v[k-1] & ~flush;
        r_pipe_id[k] <= r_pipe_id[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_resp_fire;
      r_resp_id    <= w_resp_fire ? r_pipe_id[ROM_LAT] : '0;
      r_resp_data  <= w_resp_fire ? rom_data : '0;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign rom_en     = r_rom_en;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = r_rom_en | (|r_pipe_v);

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_fetch_arbiter : directed + random bench with reference model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sprite_fetch_arbiter;
  import graphics_pkg::*;

  localparam int N      = N_REQ;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 12;
  localparam int LAT    = ROM_LAT;
  localparam int DEPTH  = 4096;

  logic                    clock;
  logic                    reset_n;
  logic [N-1:0]            req_valid;
  logic [N-1:0][ADDR_W-1:0] req_addr;
  logic [N-1:0]            req_ready;
  logic                    flush;
  logic [ADDR_W-1:0]       rom_addr;
  logic                    rom_en;
  logic [DATA_W-1:0]       rom_data;
  logic                    resp_valid;
  logic [2:0]              resp_id;
  logic [DATA_W-1:0]       resp_data;
  logic                    busy;

  sprite_fetch_arbiter #(
    .N_REQ   (N),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (LAT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .flush      (flush),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[11:0] ^ {a[13:12], a[13:4]} ^ 12'h5A3;
  endfunction

  // Sprite ROM: data for an address strobed at cycle t appears at cycle t+2.
  logic              rq1_en, rq2_en;
  logic [ADDR_W-1:0] rq1_a, rq2_a;
  logic [DATA_W-1:0] rom_junk;
  always @(posedge clock) begin
    rq1_en   <= rom_en;
    rq1_a    <= rom_addr;
    rq2_en   <= rq1_en;
    rq2_a    <= rq1_a;
    rom_junk <= DATA_W'($urandom);
  end
  assign rom_data = rq2_en ? rom_fn(rq2_a) : rom_junk;

  // Reference model state
  int                m_ptr;
  logic              m_rom_en;
  logic [ADDR_W-1:0] m_rom_addr;
  bit                exp_rv[DEPTH];
  logic [2:0]        exp_rid[DEPTH];
  logic [DATA_W-1:0] exp_rdata[DEPTH];
  int                cyc;
  logic [N-1:0]      obs_ready;
  int                n_cmp;
  int                n_fail;
  int                ord[6] = '{0, 1, 2, 3, 4, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  // One clock cycle: entered and left at posedge+1 with inputs already applied.
  task automatic tick();
    int           gi;
    logic [N-1:0] want_ready;
    logic         want_busy;
    #1;
    gi = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (gi < 0 && req_valid[j]) gi = j;
    end
    want_ready = (gi >= 0) ? N'(1 << gi) : '0;
    obs_ready  = req_ready;
    chk("req_ready", 32'(req_ready), 32'(want_ready));
    chk("rom_en", 32'(rom_en), 32'(m_rom_en));
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv[cyc]));
    if (exp_rv[cyc]) begin
      chk("resp_id", 32'(resp_id), 32'(exp_rid[cyc]));
      chk("resp_data", 32'(resp_data), 32'(exp_rdata[cyc]));
    end else begin
      chk("resp_data_idle", 32'(resp_data), 32'h0);
    end
    want_busy = m_rom_en;
    for (int k = 1; k <= LAT + 1; k++) want_busy = want_busy | exp_rv[cyc + k];
    chk("busy", 32'(busy), 32'(want_busy));

    m_rom_en = (gi >= 0);
    if (flush) for (int k = 1; k <= LAT + 2; k++) exp_rv[cyc + k] = 1'b0;
    if (gi >= 0) begin
      m_rom_addr = req_addr[gi];
      m_ptr      = (gi + 1) % N;
      if (!flush) begin
        exp_rv[cyc + LAT + 2]    = 1'b1;
        exp_rid[cyc + LAT + 2]   = 3'(gi);
        exp_rdata[cyc + LAT + 2] = rom_fn(req_addr[gi]);
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_rom_en", 32'(rom_en), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    m_ptr      = 0;
    m_rom_en   = 1'b0;
    m_rom_addr = '0;
    for (int k = 0; k < DEPTH; k++) exp_rv[k] = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc += 2;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset_n   = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    flush     = 1'b0;
    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 16;
    for (int k = 0; k < DEPTH; k++) exp_rv[k] = 1'b0;
    #2;
    do_reset();

    // Single player-0 fetch at 0x0123
    req_valid   = 5'b00001;
    req_addr[0] = 14'h0123;
    tick();
    req_valid = '0;
    chk("rom_en_single", 32'(rom_en), 32'h1);
    chk("rom_addr_single", 32'(rom_addr), 32'h0123);
    tick(); tick(); tick();
    chk("resp_valid_single", 32'(resp_valid), 32'h1);
    chk("resp_id_single", 32'(resp_id), 32'h0);
    chk("resp_data_single", 32'(resp_data), 32'(rom_fn(14'h0123)));
    idle(3);

    // All five held valid from reset: strict rotation, back-to-back responses
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i] = ADDR_W'($urandom);
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rotation_order", 32'(obs_ready), 32'(1 << ord[k]));
    end
    idle(7);

    // Pointer at 3 with requesters 0 and 2 pending: search wraps 3,4,0
    req_valid = 5'b00100;
    tick();
    req_valid = 5'b00101;
    tick();
    chk("wrap_pick0", 32'(obs_ready), 32'h01);
    req_valid = 5'b00100;
    tick();
    chk("wrap_then2", 32'(obs_ready), 32'h04);
    idle(5);

    // Three reads in flight, then flush: none return, busy drops
    req_valid = 5'b00001;
    for (int k = 0; k < 3; k++) begin
      req_addr[0] = ADDR_W'($urandom);
      tick();
    end
    req_valid = '0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("busy_after_flush", 32'(busy), 32'h0);
    idle(3);
    req_valid   = 5'b00010;
    req_addr[1] = ADDR_W'($urandom);
    tick();
    idle(5);

    // Transfer in the flush cycle is granted but never answered
    req_valid   = 5'b01000;
    req_addr[3] = ADDR_W'($urandom);
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    idle(5);

    // Reset with two reads in flight
    req_valid = 5'b00011;
    tick();
    tick();
    req_valid = '0;
    do_reset();
    req_valid = '1;
    tick();
    chk("first_after_reset", 32'(obs_ready), 32'h01);
    idle(6);

    // Random traffic with occasional flush
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_addr[i]  = ADDR_W'($urandom);
        end
      end
      flush = ($urandom % 25 == 0);
      tick();
      flush = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (obs_ready[i]) begin
          if ($urandom % 2 == 0) req_valid[i] = 1'b0;
          else req_addr[i] = ADDR_W'($urandom);
        end
      end
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
